// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: IF/LS request-response buses plus the ROM address/data port.
// master = core pipeline and ROM side, slave = rom_arbiter.
interface rom_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req;
   logic [ADDR_W-1:0] ls_addr;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_rdata;
   modport master (
      output if_req, if_addr, if_flush, ls_req, ls_addr, rom_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, rom_addr
   );
   modport slave (
      input  if_req, if_addr, if_flush, ls_req, ls_addr, rom_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, rom_addr
   );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a 1-cycle-latency ROM between IF and LS, routing each response to its owner.
// ROM_ARB_RR_EN defined selects round-robin on contention; otherwise LS has fixed priority.
module rom_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input logic          clk,
   input logic          rst_n,
   rom_arbiter_if.slave bus
);
   logic              rsp_vld_q, rsp_vld_d;
   logic              rsp_own_q, rsp_own_d;
   logic              flushed_q, flushed_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [DATA_W-1:0] rdata;
   logic              ls_win;
`ifdef ROM_ARB_RR_EN
   logic              ptr_q, ptr_d;
`endif
   assign rdata = bus.rom_rdata;
   always_comb begin
`ifdef ROM_ARB_RR_EN
      ls_win = bus.ls_req && (!bus.if_req || ptr_q);
      // pointer moves to the loser only when both contend
      ptr_d  = (bus.if_req && bus.ls_req) ? !ls_win : ptr_q;
`else
      ls_win = bus.ls_req;
`endif
      bus.ls_gnt    = rst_n && ls_win;
      bus.if_gnt    = rst_n && bus.if_req && !ls_win;
      bus.rom_addr  = bus.ls_gnt ? bus.ls_addr : bus.if_gnt ? bus.if_addr : last_addr_q;
      last_addr_d   = bus.rom_addr;
      rsp_vld_d     = bus.if_gnt || bus.ls_gnt;
      rsp_own_d     = bus.ls_gnt;
      flushed_d     = bus.if_gnt && bus.if_flush;
      bus.if_rvalid = rst_n && rsp_vld_q && !rsp_own_q && !flushed_q && !bus.if_flush;
      bus.ls_rvalid = rst_n && rsp_vld_q && rsp_own_q;
      bus.if_rdata  = rdata;
      bus.ls_rdata  = rdata;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_vld_q   <= 1'b0;
         rsp_own_q   <= 1'b0;
         flushed_q   <= 1'b0;
         last_addr_q <= '0;
`ifdef ROM_ARB_RR_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         rsp_vld_q   <= rsp_vld_d;
         rsp_own_q   <= rsp_own_d;
         flushed_q   <= flushed_d;
         last_addr_q <= last_addr_d;
`ifdef ROM_ARB_RR_EN
         ptr_q       <= ptr_d;
`endif
      end
   end
endmodule
